// File: rtl/sequencer_def.sv
// sequencer_def: shared host opcodes, controller states and default run limits
package sequencer_def;
    typedef enum logic [1:0] {OP_NOP, OP_WRITE, OP_READ, OP_RUN} host_op_e;
    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_START, S_RUN} seq_state_e;
    localparam int          DEF_START_CYCLES = 2;
    localparam logic [31:0] DEF_TIMEOUT      = 32'd1_000_000;
endpackage

// File: rtl/run_cycle_timer.sv
// run_cycle_timer: 32-bit run cycle counter with clear, enable and a match one short of TIMEOUT
module run_cycle_timer
    import sequencer_def::*;
#(
    parameter logic [31:0] TIMEOUT = DEF_TIMEOUT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        en,
    output logic [31:0] count,
    output logic        term
);
    always_ff @(posedge clk) begin
        if (reset || clear) count <= '0;
        else if (en) count <= count + 32'd1;
    end

    assign term = count == TIMEOUT - 32'd1;
endmodule

// File: rtl/run_sequencer.sv
// run_sequencer: arbitrates data_mem between host and core and sequences one core run
module run_sequencer
    import sequencer_def::*;
#(
    parameter int          START_CYCLES = DEF_START_CYCLES,
    parameter logic [31:0] TIMEOUT      = DEF_TIMEOUT,
    parameter int          A            = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         host_cmd_valid,
    output logic         host_cmd_ready,
    input  logic [1:0]   host_cmd_op,
    input  logic [A-1:0] host_addr,
    input  logic [7:0]   host_wdata,
    output logic         host_rsp_valid,
    output logic [7:0]   host_rdata,
    output logic         core_start,
    input  logic         core_halt,
    input  logic [A-1:0] core_mem_addr,
    input  logic         core_mem_read,
    input  logic         core_mem_write,
    input  logic [7:0]   core_mem_wdata,
    output logic [7:0]   core_mem_rdata,
    output logic [A-1:0] mem_addr,
    output logic         mem_read,
    output logic         mem_write,
    output logic [7:0]   mem_wdata,
    input  logic [7:0]   mem_rdata,
    output logic         busy,
    output logic         done,
    output logic         timeout,
    output logic [31:0]  cycle_count
);
    seq_state_e   state;
    host_op_e     lat_op;
    logic [A-1:0] lat_addr;
    logic [7:0]   lat_wdata;
    logic [31:0]  start_left;
    logic         abort_hold;
    logic         accept;
    logic         run_go;
    logic         term;
    logic         in_run;
    logic         in_acc;

    assign host_cmd_ready = state == S_IDLE;
    assign accept         = host_cmd_valid & host_cmd_ready;
    assign run_go         = accept & (host_cmd_op == OP_RUN);
    assign in_run         = state == S_RUN;
    assign in_acc         = state == S_ACCESS;
    assign busy           = (state == S_START) | in_run;
    // abort_hold keeps a timed-out core in reset for one extra cycle
    assign core_start     = reset | (state == S_START) | abort_hold;
    assign core_mem_rdata = mem_rdata;

    run_cycle_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk  (clk),
        .reset(reset),
        .clear(run_go),
        .en   (in_run & ~core_halt),
        .count(cycle_count),
        .term (term)
    );

    always_comb begin
        mem_addr  = in_run ? core_mem_addr  : in_acc ? lat_addr : '0;
        mem_read  = in_run ? core_mem_read  : in_acc & (lat_op == OP_READ);
        mem_write = in_run ? core_mem_write : in_acc & (lat_op == OP_WRITE);
        mem_wdata = in_run ? core_mem_wdata : (in_acc & (lat_op == OP_WRITE)) ? lat_wdata : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= S_IDLE;
            lat_op         <= OP_NOP;
            lat_addr       <= '0;
            lat_wdata      <= '0;
            start_left     <= '0;
            abort_hold     <= 1'b0;
            host_rsp_valid <= 1'b0;
            host_rdata     <= '0;
            done           <= 1'b0;
            timeout        <= 1'b0;
        end else begin
            host_rsp_valid <= in_acc;
            abort_hold     <= 1'b0;
            case (state)
                S_IDLE: if (accept) begin
                    lat_op    <= host_op_e'(host_cmd_op);
                    lat_addr  <= host_addr;
                    lat_wdata <= host_wdata;
                    if (host_cmd_op == OP_RUN) begin
                        done       <= 1'b0;
                        timeout    <= 1'b0;
                        start_left <= 32'(START_CYCLES - 1);
                        state      <= S_START;
                    end else if (host_cmd_op != OP_NOP) begin
                        state <= S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    if (lat_op == OP_READ) host_rdata <= mem_rdata;
                    state <= S_IDLE;
                end
                // core_halt is deliberately not looked at here: it may be left over from the last run
                S_START: begin
                    start_left <= start_left - 32'd1;
                    if (start_left == '0) state <= S_RUN;
                end
                S_RUN: if (core_halt) begin
                    done  <= 1'b1;
                    state <= S_IDLE;
                end else if (term) begin
                    done       <= 1'b1;
                    timeout    <= 1'b1;
                    abort_hold <= 1'b1;
                    state      <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_run_sequencer.sv
// tb_run_sequencer: randomized scoreboard bench for run_sequencer with a data_mem stand-in
module tb_run_sequencer;
    localparam int SC = 2;
    localparam int TO = 100;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        host_cmd_valid = 1'b0;
    logic        host_cmd_ready;
    logic [1:0]  host_cmd_op = 2'd0;
    logic [7:0]  host_addr = 8'd0;
    logic [7:0]  host_wdata = 8'd0;
    logic        host_rsp_valid;
    logic [7:0]  host_rdata;
    logic        core_start;
    logic        core_halt = 1'b0;
    logic [7:0]  core_mem_addr = 8'd0;
    logic        core_mem_read = 1'b0;
    logic        core_mem_write = 1'b0;
    logic [7:0]  core_mem_wdata = 8'd0;
    logic [7:0]  core_mem_rdata;
    logic [7:0]  mem_addr;
    logic        mem_read;
    logic        mem_write;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic        busy;
    logic        done;
    logic        timeout;
    logic [31:0] cycle_count;

    always #5 clk = ~clk;

    run_sequencer #(.START_CYCLES(SC), .TIMEOUT(32'(TO)), .A(8)) dut (
        .clk(clk), .reset(reset),
        .host_cmd_valid(host_cmd_valid), .host_cmd_ready(host_cmd_ready),
        .host_cmd_op(host_cmd_op), .host_addr(host_addr), .host_wdata(host_wdata),
        .host_rsp_valid(host_rsp_valid), .host_rdata(host_rdata),
        .core_start(core_start), .core_halt(core_halt),
        .core_mem_addr(core_mem_addr), .core_mem_read(core_mem_read),
        .core_mem_write(core_mem_write), .core_mem_wdata(core_mem_wdata),
        .core_mem_rdata(core_mem_rdata),
        .mem_addr(mem_addr), .mem_read(mem_read), .mem_write(mem_write),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .busy(busy), .done(done), .timeout(timeout), .cycle_count(cycle_count)
    );

    // data_mem stand-in: synchronous write, combinational read
    logic [7:0] mem_arr [256];
    always @(posedge clk) if (mem_write) mem_arr[mem_addr] <= mem_wdata;
    assign mem_rdata = mem_arr[mem_addr];

    typedef struct {
        int          kind;
        logic [7:0]  data;
        int          cyc;
        logic [31:0] cnt;
        logic        dn;
        logic        to;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] ref_mem [256];
    int         cyc = 0;
    int         vectors = 0;
    int         miscompares = 0;
    logic       prev_busy = 1'b0;
    exp_t       me;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (host_rsp_valid === 1'b1) begin
            if (sb.size() == 0) chk("rsp_unexpected", 1, 0);
            else begin
                me = sb.pop_front();
                chk("rsp_kind", 32'(me.kind == 2), 0);
                chk("rsp_latency", cyc, me.cyc + 2);
                if (me.kind == 1) chk("rdata", host_rdata, me.data);
            end
        end
        if (prev_busy === 1'b1 && busy === 1'b0) begin
            if (sb.size() == 0) chk("run_end_unexpected", 1, 0);
            else begin
                me = sb.pop_front();
                chk("run_end_kind", me.kind, 2);
                chk("done", done, me.dn);
                chk("timeout", timeout, me.to);
                chk("cycle_count", cycle_count, me.cnt);
            end
        end
        if (busy === 1'b1) chk("ready_while_busy", host_cmd_ready, 0);
        prev_busy = busy;
    end

    task automatic host_cmd(input int op, input logic [7:0] a, input logic [7:0] d);
        int w = 0;
        @(posedge clk);
        #1;
        host_cmd_valid = 1'b1;
        host_cmd_op    = op[1:0];
        host_addr      = a;
        host_wdata     = d;
        @(negedge clk);
        while (!host_cmd_ready && w < 3000) begin
            w++;
            @(negedge clk);
        end
        if (!host_cmd_ready) begin
            chk("accept_timeout", 0, 1);
            host_cmd_valid = 1'b0;
            return;
        end
        if (op == 1) begin
            ref_mem[a] = d;
            sb.push_back('{0, d, cyc, 0, 1'b0, 1'b0});
        end
        if (op == 2) sb.push_back('{1, ref_mem[a], cyc, 0, 1'b0, 1'b0});
        @(posedge clk);
        #1;
        host_cmd_valid = 1'b0;
        host_cmd_op    = 2'd0;
        if (op == 1 || op == 2) begin
            @(negedge clk);
            chk("acc_mem_write", mem_write, 32'(op == 1));
            chk("acc_mem_read", mem_read, 32'(op == 2));
            chk("acc_mem_addr", mem_addr, a);
            if (op == 1) chk("acc_mem_wdata", mem_wdata, d);
        end
    endtask

    task automatic core_model(input int n_halt, input int wr_cyc, input logic [7:0] wa,
                              input logic [7:0] wd, input logic stale, input int rst_at);
        int st = 0;
        int k = 0;
        bit stop = 0;
        core_halt      = stale;
        core_mem_write = 1'b1;
        core_mem_read  = 1'b1;
        core_mem_addr  = 8'($urandom);
        core_mem_wdata = 8'($urandom);
        @(negedge clk);
        while (busy && core_start && st < 20) begin
            chk("start_mem_write", mem_write, 0);
            chk("start_mem_read", mem_read, 0);
            st++;
            @(negedge clk);
        end
        chk("start_len", st, SC);
        core_mem_read  = 1'b0;
        core_mem_write = 1'b0;
        while (busy && k < 400 && !stop) begin
            if (k == rst_at) begin
                core_mem_write = 1'b0;
                reset = 1'b1;
                @(negedge clk);
                chk("rst_core_start", core_start, 1);
                chk("rst_ready", host_cmd_ready, 1);
                reset = 1'b0;
                stop = 1;
            end else begin
                core_halt      = (k == n_halt);
                core_mem_write = (k == wr_cyc && k < n_halt && k < TO);
                core_mem_addr  = wa;
                core_mem_wdata = wd;
                if (core_mem_write) ref_mem[wa] = wd;
                #1;
                chk("run_pass_write", mem_write, core_mem_write);
                chk("run_pass_addr", mem_addr, wa);
                @(negedge clk);
                k++;
            end
        end
        core_mem_write = 1'b0;
        if (busy) chk("run_hang", 0, 1);
        if (rst_at < 0 && n_halt >= TO) chk("abort_core_start", core_start, 1);
    endtask

    task automatic push_run(input int n_halt, input int rst_at);
        exp_t e;
        e.kind = 2;
        e.data = 8'd0;
        e.cyc  = 0;
        if (rst_at >= 0) begin
            e.cnt = 0; e.dn = 1'b0; e.to = 1'b0;
        end else if (n_halt >= TO) begin
            e.cnt = 32'(TO); e.dn = 1'b1; e.to = 1'b1;
        end else begin
            e.cnt = 32'(n_halt); e.dn = 1'b1; e.to = 1'b0;
        end
        sb.push_back(e);
    endtask

    task automatic do_run(input int n_halt, input int wr_cyc, input logic [7:0] wa,
                          input logic [7:0] wd, input logic stale, input int rst_at);
        push_run(n_halt, rst_at);
        host_cmd(3, 8'd0, 8'd0);
        core_model(n_halt, wr_cyc, wa, wd, stale, rst_at);
    endtask

    initial begin
        int w;
        int n;
        int r;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_rsp_valid", host_rsp_valid, 0);
        chk("rst_rdata", host_rdata, 0);
        chk("rst_done", done, 0);
        chk("rst_timeout", timeout, 0);
        chk("rst_cycle_count", cycle_count, 0);
        chk("rst_core_start", core_start, 1);
        chk("rst_busy", busy, 0);
        chk("rst_mem_write", mem_write, 0);
        reset = 1'b0;

        for (int a = 0; a < 64; a++) host_cmd(1, 8'(a), 8'($urandom));

        host_cmd(1, 8'h10, 8'hA5);
        host_cmd(2, 8'h10, 8'h00);
        do_run(37, 5, 8'h05, 8'h77, 1'b0, -1);
        do_run(1000, 200, 8'h00, 8'h00, 1'b0, -1);
        host_cmd(2, 8'h10, 8'h00);

        push_run(10, -1);
        host_cmd(3, 8'd0, 8'd0);
        fork
            core_model(10, 3, 8'h20, 8'h3C, 1'b0, -1);
            host_cmd(1, 8'h20, 8'hFF);
        join
        host_cmd(2, 8'h20, 8'h00);

        do_run(50, 2, 8'h21, 8'h99, 1'b0, 5);
        host_cmd(2, 8'h21, 8'h00);
        do_run(0, 200, 8'h00, 8'h00, 1'b1, -1);

        for (int i = 0; i < 50; i++) begin
            r = $urandom_range(0, 9);
            if (r == 0) host_cmd(0, 8'($urandom), 8'($urandom));
            else if (r < 4) host_cmd(1, 8'($urandom_range(0, 63)), 8'($urandom));
            else if (r < 7) host_cmd(2, 8'($urandom_range(0, 63)), 8'd0);
            else begin
                n = $urandom_range(0, 130);
                do_run(n, $urandom_range(0, 30), 8'($urandom_range(0, 63)), 8'($urandom),
                       1'($urandom_range(0, 1)),
                       (n > 1 && $urandom_range(0, 5) == 0) ? $urandom_range(0, (n < TO ? n : TO) - 1) : -1);
            end
        end

        w = 0;
        while (sb.size() > 0 && w < 1000) begin
            @(negedge clk);
            w++;
        end
        chk("scoreboard_drained", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/run_sequencer.md
Name: run_sequencer

Overview:
Host-facing controller that sequences one program run of the 8-bit core (fetch unit, instruction ROM, control unit, data_mem).
- Owns the single data_mem port while the core is idle, so a host can preload operands and read back results.
- Holds the core in reset via start, releases it, then hands the memory port to the core.
- Counts executed cycles until halt, with a timeout guard.
- Sits between the bench/host and TopLevel's start/halt/data_mem connections.

Parameters:
START_CYCLES, 2, number of cycles core_start is held high before release (>=1)
TIMEOUT, 32'd1_000_000, RUN cycle count at which the run is aborted with timeout=1
A, 8, data memory address width

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
host_cmd_valid  input  1  host command present
host_cmd_ready  output  1  controller accepts command this cycle
host_cmd_op  input  2  00 NOP, 01 WRITE, 10 READ, 11 RUN
host_addr  input  A  data memory address for WRITE/READ
host_wdata  input  8  write data
host_rsp_valid  output  1  one-cycle pulse: WRITE/READ completed
host_rdata  output  8  READ result, valid with host_rsp_valid
core_start  output  1  drives core start/reset
core_halt  input  1  core halt flag
core_mem_addr  input  A  core data address
core_mem_read  input  1  core read enable
core_mem_write  input  1  core write enable
core_mem_wdata  input  8  core write data
core_mem_rdata  output  8  equals mem_rdata at all times
mem_addr  output  A  to data_mem addr
mem_read  output  1  to data_mem ctrl_mem_read
mem_write  output  1  to data_mem ctrl_mem_write
mem_wdata  output  8  to data_mem data_in
mem_rdata  input  8  from data_mem data_out (combinational read)
busy  output  1  high in START and RUN
done  output  1  sticky: last run finished
timeout  output  1  sticky: last run aborted by TIMEOUT
cycle_count  output  32  cycles executed in last/current run

Behaviour:
- Reset (sync, active-high):
  - State goes to IDLE; host_rsp_valid, host_rdata, done, timeout, cycle_count all cleared to 0.
  - core_start=1 combinationally while reset=1, so the core is held in reset.
  - data_mem contents are untouched.
- States: IDLE, ACCESS, START, RUN.
- Handshake: a command is accepted when host_cmd_valid & host_cmd_ready. host_cmd_ready=1 only in IDLE.
- IDLE:
  - Memory outputs are all 0.
  - NOP accepted: no effect.
  - WRITE/READ accepted: op, addr and wdata are latched; next state ACCESS.
  - RUN accepted: done and timeout cleared, cycle_count cleared to 0; next state START.
- ACCESS (exactly 1 cycle):
  - mem_addr = latched addr.
  - WRITE: mem_write=1, mem_wdata = latched data.
  - READ: mem_read=1; mem_rdata is registered into host_rdata.
  - host_rsp_valid=1 in the following cycle, for one cycle only; then back to IDLE.
  - Latency: accept at cycle N, response at N+2. The next command may be accepted at N+2.
- START:
  - core_start=1 for exactly START_CYCLES cycles.
  - mem_read and mem_write forced 0.
  - core_halt is ignored, since it may be stale from the previous run.
  - Then go to RUN.
- RUN:
  - core_start=0.
  - mem_addr, mem_read, mem_write and mem_wdata pass combinationally from the core_mem_* inputs.
  - Each cycle with core_halt=0: cycle_count increments.
  - core_halt=1: no increment; done<=1; go to IDLE. A halt in the first RUN cycle gives cycle_count=0.
  - If core_halt=0 and cycle_count==TIMEOUT-1: increment to TIMEOUT, set timeout<=1 and done<=1, go to IDLE. The core is then held with core_start=1 for one cycle.
- host_rdata holds its value until the next READ completes.
- cycle_count holds after a run until the next RUN is accepted or reset.
- Reset mid-RUN/START: immediate return to IDLE. The memory port returns to host ownership the next cycle.
- Host commands offered during START/RUN are not accepted (ready=0); the host must hold valid.

Decomposition:
- Package sequencer_def holds:
  - typedef enum logic[1:0] HOST_OP {NOP, WRITE, READ, RUN}
  - typedef enum SEQ_STATE {IDLE, ACCESS, START, RUN}
  - default constants for START_CYCLES and TIMEOUT
- One sub-module, run_cycle_timer: 32-bit counter with clear, enable and a terminal-match output at TIMEOUT-1.
- The FSM and the memory-port mux remain in run_sequencer.

Test Plan:
- Host WRITE addr 8'h10 data 8'hA5, then READ 8'h10: mem_write pulse at N+1, host_rsp_valid at N+2; read returns host_rdata=8'hA5.
- RUN with a program that halts after 37 cycles: core_start high exactly 2 cycles; done=1, timeout=0, cycle_count=37; ready returns to 1.
- RUN with TIMEOUT=100 and core_halt tied 0: timeout=1, done=1, cycle_count=100 exactly; following READ is served by host.
- During RUN, core writes 8'h3C to addr 8'h20 while the host holds valid with WRITE 8'h20/8'hFF: the host command is accepted only after done; final READ returns 8'hFF.
- reset asserted 5 cycles into RUN: next cycle state IDLE, cycle_count=0, done=0, core_start=1 during reset; a subsequent READ works.
- Stale core_halt=1 during START is ignored; RUN then halts on the first RUN cycle: cycle_count=0, done=1.
